enc_scan_ctrl: RTL and testbench
================================

// Module: enc_scan_ctrl
// PURPOSE
// - Time-multiplexed scanner for a bank of CH rotary encoders and pushbuttons that share one set of input pins
//   through an external analog mux. Drives mux select, waits settle time, samples, decodes quadrature per channel.
// - Accumulates a signed count and a sticky press flag per channel; both are read through an rbus register
//   (clear-on-read strobe rd_i). Sits between board mux pins and the rbus encoder register.
// PARAMETERS
// - CH        8   number of muxed channels (power of 2, >=2)
// - SEL_W     3   mux select width = log2(CH)
// - CNT_W     4   per-channel signed accumulator width
// - SYNC_W    2   input synchronizer depth
// - SETTLE    16  settle cycles after select change; must be >= SYNC_W+1
// - SETTLE_W  5   settle counter width, holds SETTLE
// PORTS
// - clk_i         in   1           clock
// - rst_n_i       in   1           reset, asynchronous, active-low
// - sel_o         out  SEL_W       external mux select
// - enc_i         in   2           muxed quadrature inputs {B,A}, asynchronous
// - pb_i          in   1           muxed pushbutton input, active-high, asynchronous
// - rd_i          in   1           register read strobe, 1 cycle; clears counts/flags
// - cnt_o         out  CH*CNT_W    signed counts, channel k at [k*CNT_W +: CNT_W]
// - pb_o          out  CH          sticky press flags, channel k at bit k
// - scan_done_o   out  1           1-cycle pulse at end of each full scan
// BEHAVIOUR
// - Reset (rst_n_i low, any time): sel_o=0, cnt_o=0, pb_o=0, scan_done_o=0, all prev/valid cleared, FSM=SEL.
// - enc_i/pb_i pass through SYNC_W-flop synchronizer before use; sampling uses synchronized values only.
// - FSM per channel: SEL (1 cycle: sel_o<=ch, settle cnt<=SETTLE-1) -> SETTLE (count down to 0)
//   -> SAMPLE (1 cycle: decode, update) -> SEL of ch+1; ch wraps CH-1 -> 0.
// - Channel period = SETTLE+2 cycles; full scan = CH*(SETTLE+2) cycles.
// - scan_done_o high exactly in the cycle after SAMPLE of ch=CH-1.
// - Quadrature decode (prev->cur, Gray order 00->01->11->10->00 = +1, reverse = -1):
//   no change = 0; both bits change = invalid, delta 0, prev still updated.
// - First SAMPLE of a channel after reset loads prev and sets valid; no count.
// - Accumulate: cnt[k] <= sat(cnt[k]+delta); saturate at +(2^(CNT_W-1)-1) and -(2^(CNT_W-1)-1);
//   most-negative code never produced.
// - pb: SAMPLE with pb high sets pb_o[k]; never cleared by release, only by rd_i.
// - rd_i: at next edge all cnt and pb_o cleared. If same cycle is SAMPLE of ch k: cnt[k] <= delta (sat),
//   pb_o[k] <= sampled pb; no event is lost. Other channels cleared.
// - rd_i does not disturb FSM, sel_o, prev or valid state.
// - cnt_o/pb_o are registered; stable between SAMPLE cycles.
// STRUCTURE
// - Shared package enc_scan_pkg: typedef enum {SEL, SETTLE, SAMPLE} enc_scan_state_t;
//   function qdec(prev[1:0], cur[1:0]) -> signed [1:0]; function sat_add(cnt, delta) by CNT_W.
// - Sub-module enc_scan_sync: SYNC_W-deep 3-bit synchronizer, async active-low reset to 0.
// - Top: FSM, settle counter, channel counter, per-channel prev[2]/valid/cnt/pb arrays.
// TESTING
// - Reset mid-scan (SETTLE of ch 5, cnt[3]=+2): assert rst_n_i low async
//   -> all outputs 0 immediately; restart at ch 0 with first samples count 0.
// - Ch 2 sees 00,01,11,10,00 across 4 successive scans after init
//   -> cnt[2]=+4 (0x4); reverse sequence -> -4 (0xC); other channels 0.
// - 10 forward steps on ch 0 with CNT_W=4 -> cnt[0]=+7 held;
//   then 16 reverse -> -7 (0x9), never 0x8.
// - Invalid jump 00->11 on ch 6 -> cnt[6] unchanged; next 11->10 -> +1.
// - pb on ch 7 high one sample then low -> pb_o[7]=1 until rd_i, then 0;
//   rd_i in same cycle as ch 7 SAMPLE with pb high -> pb_o[7] stays 1.
// - rd_i coincident with ch 1 SAMPLE of +1 (cnt[1]=+3) -> cnt[1]=+1, others 0;
//   scan_done_o period = 8*18=144 cycles at defaults.

Source files
------------

// File: rtl/enc_scan_pkg.sv
// enc_scan_pkg: scan FSM state type plus quadrature-decode and saturating-add helpers
package enc_scan_pkg;
  typedef enum logic [1:0] {SEL = 2'd0, SETTLE = 2'd1, SAMPLE = 2'd2} enc_scan_state_t;
  // Gray {B,A} is mapped to its position on the 00->01->11->10 cycle; a step of +1/-1 is a count
  function automatic logic signed [1:0] qdec(input logic [1:0] prev, input logic [1:0] cur);
    logic [1:0] d;
    d = {cur[1], ^cur} - {prev[1], ^prev};
    return d == 2'd1 ? 2'sd1 : d == 2'd3 ? -2'sd1 : 2'sd0;
  endfunction
  // Symmetric saturation: the most-negative w-bit code is never produced
  function automatic int sat_add(input int cnt, input int delta, input int w);
    int lim, s;
    lim = (1 << (w - 1)) - 1;
    s = cnt + delta;
    return s > lim ? lim : s < -lim ? -lim : s;
  endfunction
endpackage

// File: rtl/enc_scan_sync.sv
// enc_scan_sync: SYNC_W-deep synchronizer for the muxed {pb,B,A} pins
// Ports: clk_i/rst_n_i clock and async active-low reset, d_i async input, q_o synchronized output
module enc_scan_sync #(
  parameter int SYNC_W = 2,
  parameter int W      = 3
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] ff_q [SYNC_W];
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < SYNC_W; i++) ff_q[i] <= '0;
    end else begin
      ff_q[0] <= d_i;
      for (int i = 1; i < SYNC_W; i++) ff_q[i] <= ff_q[i-1];
    end
  end
  assign q_o = ff_q[SYNC_W-1];
endmodule

// File: rtl/enc_scan_ctrl.sv
// enc_scan_ctrl: time-multiplexed scanner for CH muxed quadrature encoders and pushbuttons
// Ports: sel_o drives the external mux; enc_i/pb_i are the shared async pins; rd_i clears
// cnt_o (signed per-channel counts) and pb_o (sticky presses); scan_done_o pulses once per scan
module enc_scan_ctrl
  import enc_scan_pkg::*;
#(
  parameter int CH       = 8,
  parameter int SEL_W    = 3,
  parameter int CNT_W    = 4,
  parameter int SYNC_W   = 2,
  parameter int SETTLE   = 16,
  parameter int SETTLE_W = 5
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  output logic [SEL_W-1:0]    sel_o,
  input  logic [1:0]          enc_i,
  input  logic                pb_i,
  input  logic                rd_i,
  output logic [CH*CNT_W-1:0] cnt_o,
  output logic [CH-1:0]       pb_o,
  output logic                scan_done_o
);
  enc_scan_state_t         state_q, state_d;
  logic [SEL_W-1:0]        ch_q, ch_d, sel_q, sel_d;
  logic [SETTLE_W-1:0]     set_q, set_d;
  logic                    done_q, done_d;
  logic [1:0]              prev_q [CH];
  logic [1:0]              prev_d [CH];
  logic [CH-1:0]           valid_q, valid_d, pb_q, pb_d;
  logic signed [CNT_W-1:0] cnt_q [CH];
  logic signed [CNT_W-1:0] cnt_d [CH];
  logic [2:0]              in_s;
  logic [1:0]              enc_s;
  logic                    pb_s, smp;
  logic signed [1:0]       dlt;

  enc_scan_sync #(.SYNC_W(SYNC_W), .W(3)) u_sync (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .d_i     ({pb_i, enc_i}),
    .q_o     (in_s)
  );

  assign enc_s = in_s[1:0];
  assign pb_s  = in_s[2];
  assign smp   = state_q == enc_scan_pkg::SAMPLE;
  // The first sample after reset only seeds prev, so it never produces a count
  assign dlt   = valid_q[ch_q] ? qdec(prev_q[ch_q], enc_s) : 2'sd0;

  // The parameter SETTLE shadows the state name, hence the package-scoped state references
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    sel_d   = sel_q;
    set_d   = set_q;
    case (state_q)
      enc_scan_pkg::SEL: begin
        sel_d   = ch_q;
        set_d   = SETTLE_W'(SETTLE - 1);
        state_d = enc_scan_pkg::SETTLE;
      end
      enc_scan_pkg::SETTLE: begin
        set_d   = set_q - SETTLE_W'(1);
        state_d = set_q == '0 ? enc_scan_pkg::SAMPLE : enc_scan_pkg::SETTLE;
      end
      enc_scan_pkg::SAMPLE: begin
        ch_d    = ch_q + SEL_W'(1);
        state_d = enc_scan_pkg::SEL;
      end
      default: state_d = enc_scan_pkg::SEL;
    endcase
    done_d = smp && ch_q == SEL_W'(CH - 1);
  end

  // A read clears everything first, then the sampled channel re-accumulates from zero so its event survives
  always_comb begin
    valid_d = valid_q;
    pb_d    = rd_i ? '0 : pb_q;
    for (int k = 0; k < CH; k++) begin
      prev_d[k] = prev_q[k];
      cnt_d[k]  = rd_i ? '0 : cnt_q[k];
    end
    if (smp) begin
      cnt_d[ch_q]   = CNT_W'(sat_add(int'(cnt_d[ch_q]), int'(dlt), CNT_W));
      pb_d[ch_q]    = pb_d[ch_q] | pb_s;
      prev_d[ch_q]  = enc_s;
      valid_d[ch_q] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= enc_scan_pkg::SEL;
      ch_q    <= '0;
      sel_q   <= '0;
      set_q   <= '0;
      done_q  <= 1'b0;
      valid_q <= '0;
      pb_q    <= '0;
      for (int k = 0; k < CH; k++) begin
        prev_q[k] <= '0;
        cnt_q[k]  <= '0;
      end
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      sel_q   <= sel_d;
      set_q   <= set_d;
      done_q  <= done_d;
      valid_q <= valid_d;
      pb_q    <= pb_d;
      for (int k = 0; k < CH; k++) begin
        prev_q[k] <= prev_d[k];
        cnt_q[k]  <= cnt_d[k];
      end
    end
  end

  for (genvar g = 0; g < CH; g++) begin : g_cnt
    assign cnt_o[g*CNT_W +: CNT_W] = cnt_q[g];
  end
  assign sel_o       = sel_q;
  assign pb_o        = pb_q;
  assign scan_done_o = done_q;
endmodule

// File: tb/tb_enc_scan_ctrl.sv
// tb_enc_scan_ctrl: scoreboard bench for enc_scan_ctrl with an external mux model and per-scan reference model
module tb_enc_scan_ctrl;
  localparam int CH = 8, SEL_W = 3, CNT_W = 4, SYNC_W = 2, SETTLE = 16, SETTLE_W = 5;
  localparam int PER = SETTLE + 2, SCAN = CH * PER, LIM = (1 << (CNT_W - 1)) - 1;

  logic                clk_i = 1'b0, rst_n_i = 1'b0, rd_i = 1'b0;
  logic [1:0]          enc_i;
  logic                pb_i, scan_done_o;
  logic [SEL_W-1:0]    sel_o;
  logic [CH*CNT_W-1:0] cnt_o;
  logic [CH-1:0]       pb_o;

  // Physical pin state of each channel; the analog mux routes the selected one to the DUT
  logic [1:0] phys_enc [CH];
  logic       phys_pb  [CH];
  assign enc_i = phys_enc[sel_o];
  assign pb_i  = phys_pb[sel_o];

  always #5 clk_i = ~clk_i;

  enc_scan_ctrl #(
    .CH(CH), .SEL_W(SEL_W), .CNT_W(CNT_W), .SYNC_W(SYNC_W), .SETTLE(SETTLE), .SETTLE_W(SETTLE_W)
  ) dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .sel_o       (sel_o),
    .enc_i       (enc_i),
    .pb_i        (pb_i),
    .rd_i        (rd_i),
    .cnt_o       (cnt_o),
    .pb_o        (pb_o),
    .scan_done_o (scan_done_o)
  );

  typedef struct {
    logic [CH*CNT_W-1:0] cnt;
    logic [CH-1:0]       pb;
  } exp_t;

  exp_t sb[$];
  exp_t got;
  int   checks = 0, failures = 0, cyc = 0, last_sd = -1;
  int   m_cnt [CH];
  logic [1:0] m_prev [CH];
  bit   m_valid [CH];
  bit   m_pb [CH];
  // Gray code <-> position on the 00,01,11,10 cycle (the mapping is its own inverse)
  int   gpos [4] = '{0, 1, 3, 2};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic summary();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
  endtask

  function automatic int step(input logic [1:0] p, input logic [1:0] c);
    int d;
    d = (gpos[c] - gpos[p] + 4) % 4;
    return d == 1 ? 1 : d == 3 ? -1 : 0;
  endfunction

  function automatic int clamp(input int v);
    return v > LIM ? LIM : v < -LIM ? -LIM : v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < CH; k++) begin
      m_cnt[k] = 0; m_pb[k] = 0; m_valid[k] = 0; m_prev[k] = 2'd0;
    end
  endtask

  // Called at the negedge inside the cycle where channel 0 is being selected. c<0: no read;
  // otherwise rd_i is high during scan cycle offset c (channel k samples at offset k*PER+PER-1).
  task automatic do_scan(input int c);
    exp_t e;
    int   n;
    for (int k = 0; k < CH; k++) begin
      int d, base;
      bit bpb;
      d = m_valid[k] ? step(m_prev[k], phys_enc[k]) : 0;
      m_prev[k]  = phys_enc[k];
      m_valid[k] = 1;
      if (c >= 0 && k * PER + PER - 1 < c) begin
        m_cnt[k] = 0;
        m_pb[k]  = 0;
      end else begin
        base     = c >= 0 ? 0 : m_cnt[k];
        bpb      = c >= 0 ? 1'b0 : m_pb[k];
        m_cnt[k] = clamp(base + d);
        m_pb[k]  = bpb | phys_pb[k];
      end
      e.cnt[k*CNT_W +: CNT_W] = CNT_W'(m_cnt[k]);
      e.pb[k] = m_pb[k];
    end
    sb.push_back(e);
    if (c >= 0) begin
      if (c > 0) begin
        repeat (c) @(posedge clk_i);
        #1;
      end
      rd_i = 1'b1;
      @(posedge clk_i);
      #1 rd_i = 1'b0;
    end
    n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while (!scan_done_o && n < SCAN + 20);
    if (!scan_done_o) begin
      checks++;
      failures++;
      $display("FAIL scan_timeout actual=no scan_done_o required=pulse within %0d cycles", SCAN + 20);
      summary();
      $finish;
    end
  endtask

  always @(posedge clk_i) cyc++;

  // Monitor: every scan_done_o pulse retires one expected scan result
  initial forever begin
    @(negedge clk_i);
    if (!rst_n_i) last_sd = -1;
    else if (scan_done_o) begin
      if (last_sd >= 0) chk("scan_period", 64'(cyc - last_sd), 64'(SCAN));
      last_sd = cyc;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_underflow actual=scan_done_o with no pending scan required=pending scan");
      end else begin
        got = sb.pop_front();
        chk("cnt_o", 64'(cnt_o), 64'(got.cnt));
        chk("pb_o", 64'(pb_o), 64'(got.pb));
      end
    end
  end

  initial begin
    for (int k = 0; k < CH; k++) begin
      phys_enc[k] = 2'd0;
      phys_pb[k]  = 1'b0;
    end
    model_reset();
    repeat (3) @(negedge clk_i);
    chk("rst0_cnt", 64'(cnt_o), 64'd0);
    chk("rst0_pb", 64'(pb_o), 64'd0);
    chk("rst0_sel", 64'(sel_o), 64'd0);
    chk("rst0_done", 64'(scan_done_o), 64'd0);
    rst_n_i = 1'b1;
    do_scan(-1);
    // ch2 forward through one full Gray cycle; ch3 two forward steps then holds
    for (int i = 1; i <= 4; i++) begin
      phys_enc[2] = 2'(gpos[i % 4]);
      phys_enc[3] = 2'(gpos[i < 3 ? i : 2]);
      do_scan(-1);
    end
    // Asynchronous reset while channel 5 is settling
    repeat (5 * PER + 5) @(posedge clk_i);
    #3 rst_n_i = 1'b0;
    #1;
    chk("arst_cnt", 64'(cnt_o), 64'd0);
    chk("arst_pb", 64'(pb_o), 64'd0);
    chk("arst_sel", 64'(sel_o), 64'd0);
    chk("arst_done", 64'(scan_done_o), 64'd0);
    sb.delete();
    model_reset();
    repeat (2) @(negedge clk_i);
    rst_n_i = 1'b1;
    do_scan(-1);
    // ch2 reverse through one full Gray cycle
    for (int i = 1; i <= 4; i++) begin
      phys_enc[2] = 2'(gpos[(4 - i) % 4]);
      do_scan(-1);
    end
    do_scan(0);
    // ch0 saturation: 10 forward, then 16 reverse
    for (int i = 1; i <= 10; i++) begin
      phys_enc[0] = 2'(gpos[i % 4]);
      do_scan(-1);
    end
    for (int i = 1; i <= 16; i++) begin
      phys_enc[0] = 2'(gpos[(10 - i + 16) % 4]);
      do_scan(-1);
    end
    // ch6 invalid jump 00->11, then a valid 11->10
    phys_enc[6] = 2'd3;
    do_scan(-1);
    phys_enc[6] = 2'd2;
    do_scan(-1);
    // ch7 sticky press, cleared by a read, then a read coincident with a pressed sample
    phys_pb[7] = 1'b1;
    do_scan(-1);
    phys_pb[7] = 1'b0;
    do_scan(-1);
    do_scan(-1);
    do_scan(60);
    phys_pb[7] = 1'b1;
    do_scan(7 * PER + PER - 1);
    phys_pb[7] = 1'b0;
    // ch1 to +3, then a read coincident with a +1 sample on ch1
    for (int i = 1; i <= 3; i++) begin
      phys_enc[1] = 2'(gpos[i % 4]);
      do_scan(-1);
    end
    phys_enc[1] = 2'(gpos[0]);
    do_scan(PER + PER - 1);
    // Randomized scans: steps, holds, invalid jumps, presses and reads at random offsets
    for (int s = 0; s < 30; s++) begin
      int c, r;
      for (int k = 0; k < CH; k++) begin
        r = int'($urandom_range(0, 3));
        if (r == 1) phys_enc[k] = 2'(gpos[(gpos[phys_enc[k]] + 1) % 4]);
        else if (r == 2) phys_enc[k] = 2'(gpos[(gpos[phys_enc[k]] + 3) % 4]);
        else if (r == 3) phys_enc[k] = 2'($urandom_range(0, 3));
        phys_pb[k] = $urandom_range(0, 7) == 0;
      end
      r = int'($urandom_range(0, 3));
      c = r == 0 ? -1 : r == 1 ? int'($urandom_range(0, CH - 1)) * PER + PER - 1 : int'($urandom_range(0, SCAN - 1));
      do_scan(c);
    end
    @(negedge clk_i);
    chk("sb_drain", 64'(sb.size()), 64'd0);
    summary();
    $finish;
  end
endmodule
